// File: rtl/draw_scene_sequencer.sv
// Frame sequencer: background redraw, then one gold/stone draw per present slot, with VGA mux select.
// Per-request latency set by the drawers' done pulses; each scan visits one slot per cycle.
module draw_scene_sequencer #(
  parameter int NUM_GOLD  = 8,
  parameter int NUM_STONE = 8,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_tick,
  input  logic [NUM_GOLD-1:0]  gold_valid,
  input  logic [NUM_STONE-1:0] stone_valid,
  input  logic                 draw_background_done,
  input  logic                 draw_gold_done,
  input  logic                 draw_stone_done,
  output logic                 enable_draw_background,
  output logic                 enable_draw_gold,
  output logic                 enable_draw_stone,
  output logic [IDX_W-1:0]     obj_index,
  output logic [1:0]           draw_sel,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_overrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_BG_REQ, S_BG_WAIT,
    S_GOLD_SCAN, S_GOLD_REQ, S_GOLD_WAIT,
    S_STONE_SCAN, S_STONE_REQ, S_STONE_WAIT,
    S_FRAME_DONE
  } state_t;

  localparam int PAD_W = 2**IDX_W;
  localparam logic [IDX_W-1:0] LP_GOLD_END  = IDX_W'(NUM_GOLD);
  localparam logic [IDX_W-1:0] LP_STONE_END = IDX_W'(NUM_STONE);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [NUM_GOLD-1:0]    r_gold_mask;
  logic [NUM_STONE-1:0]   r_stone_mask;
  logic                   r_overrun;
  logic [PAD_W-1:0]       w_gold_pad;
  logic [PAD_W-1:0]       w_stone_pad;
  logic                   w_tick_drop;

  // Masks padded to the full index range so the index selects a bit without width games.
  assign w_gold_pad  = {{(PAD_W-NUM_GOLD){1'b0}}, r_gold_mask};
  assign w_stone_pad = {{(PAD_W-NUM_STONE){1'b0}}, r_stone_mask};
  assign w_tick_drop = frame_tick && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_gold_mask  <= '0;
      r_stone_mask <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_overrun <= w_tick_drop;
      if (r_state == S_IDLE && frame_tick) begin
        r_gold_mask  <= gold_valid;
        r_stone_mask <= stone_valid;
      end
    end
  end

  always_comb begin
    w_state_nxt            = r_state;
    w_idx_nxt              = r_idx;
    enable_draw_background = 1'b0;
    enable_draw_gold       = 1'b0;
    enable_draw_stone      = 1'b0;
    draw_sel               = 2'd0;
    busy                   = 1'b1;
    frame_done             = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_tick) w_state_nxt = S_BG_REQ;
      end
      S_BG_REQ: begin
        enable_draw_background = 1'b1;
        draw_sel               = 2'd1;
        w_state_nxt            = S_BG_WAIT;
      end
      S_BG_WAIT: begin
        draw_sel = 2'd1;
        if (draw_background_done) begin
          w_state_nxt = S_GOLD_SCAN;
          w_idx_nxt   = '0;
        end
      end
      S_GOLD_SCAN: begin
        if (r_idx == LP_GOLD_END) begin
          w_state_nxt = S_STONE_SCAN;
          w_idx_nxt   = '0;
        end else if (w_gold_pad[r_idx]) begin
          w_state_nxt = S_GOLD_REQ;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_GOLD_REQ: begin
        enable_draw_gold = 1'b1;
        draw_sel         = 2'd2;
        w_state_nxt      = S_GOLD_WAIT;
      end
      S_GOLD_WAIT: begin
        draw_sel = 2'd2;
        if (draw_gold_done) begin
          w_state_nxt = S_GOLD_SCAN;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_STONE_SCAN: begin
        if (r_idx == LP_STONE_END) begin
          w_state_nxt = S_FRAME_DONE;
        end else if (w_stone_pad[r_idx]) begin
          w_state_nxt = S_STONE_REQ;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_STONE_REQ: begin
        enable_draw_stone = 1'b1;
        draw_sel          = 2'd3;
        w_state_nxt       = S_STONE_WAIT;
      end
      S_STONE_WAIT: begin
        draw_sel = 2'd3;
        if (draw_stone_done) begin
          w_state_nxt = S_STONE_SCAN;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_FRAME_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign obj_index     = r_idx;
  assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_draw_scene_sequencer.sv
// Directed bench for draw_scene_sequencer: drawer responder, event monitor, hand-computed expectations.
module tb_draw_scene_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] gold_valid = 8'h00;
  logic [7:0] stone_valid = 8'h00;
  logic       bg_done_r = 1'b0, gold_done_r = 1'b0, stone_done_r = 1'b0;
  logic       spur_gold = 1'b0, spur_stone = 1'b0;
  logic       en_bg, en_gold, en_stone, busy, frame_done, frame_overrun;
  logic [3:0] obj_index;
  logic [1:0] draw_sel;

  int bg_dly = 5, gold_dly = 2, stone_dly = 2;
  int cyc = 0;
  int tick_cyc = 0;
  int n_vec = 0, n_err = 0;
  logic clr_tog = 1'b0, clr_seen = 1'b0;

  int n_bg, n_fd, n_ovr, bg_en_cyc, bgd_cyc, fd_cyc;
  int gold_q[$], stone_q[$], sel_q[$];

  draw_scene_sequencer #(.NUM_GOLD(8), .NUM_STONE(8), .IDX_W(4)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .gold_valid(gold_valid), .stone_valid(stone_valid),
    .draw_background_done(bg_done_r),
    .draw_gold_done(gold_done_r | spur_gold),
    .draw_stone_done(stone_done_r | spur_stone),
    .enable_draw_background(en_bg), .enable_draw_gold(en_gold),
    .enable_draw_stone(en_stone), .obj_index(obj_index), .draw_sel(draw_sel),
    .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: records every event in the cycle it is visible.
  initial begin
    n_bg = 0; n_fd = 0; n_ovr = 0; bg_en_cyc = 0; bgd_cyc = 0; fd_cyc = 0;
    forever begin
      @(negedge clk);
      if (clr_tog != clr_seen) begin
        clr_seen = clr_tog;
        n_bg = 0; n_fd = 0; n_ovr = 0;
        gold_q.delete(); stone_q.delete(); sel_q.delete();
      end
      if (en_bg)    begin n_bg++; bg_en_cyc = cyc; sel_q.push_back(int'(draw_sel)); end
      if (en_gold)  begin gold_q.push_back(int'(obj_index)); sel_q.push_back(int'(draw_sel)); end
      if (en_stone) begin stone_q.push_back(int'(obj_index)); sel_q.push_back(int'(draw_sel)); end
      if (bg_done_r && busy) bgd_cyc = cyc;
      if (frame_done) begin n_fd++; fd_cyc = cyc; end
      if (frame_overrun) n_ovr++;
    end
  end

  // Drawer model: answers a request after a per-type delay; delay 0 never answers.
  initial forever begin
    @(negedge clk);
    if (en_bg && bg_dly != 0) begin
      repeat (bg_dly) @(posedge clk);
      #1 bg_done_r = 1'b1;
      @(posedge clk); #1 bg_done_r = 1'b0;
    end else if (en_gold && gold_dly != 0) begin
      repeat (gold_dly) @(posedge clk);
      #1 gold_done_r = 1'b1;
      @(posedge clk); #1 gold_done_r = 1'b0;
    end else if (en_stone && stone_dly != 0) begin
      repeat (stone_dly) @(posedge clk);
      #1 stone_done_r = 1'b1;
      @(posedge clk); #1 stone_done_r = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int q[$]);
    logic [31:0] r;
    r = 32'h0;
    foreach (q[i]) r = (r << 4) | 32'(q[i] & 15);
    return r;
  endfunction

  task automatic clr();
    clr_tog = ~clr_tog;
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic pulse_tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    tick_cyc = cyc;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int k;
    k = 0;
    while (n_fd == 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_fd_seen"}, 32'(n_fd != 0), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_cnt(input int which, input int target);
    int k;
    int c;
    k = 0;
    c = 0;
    while (k < 3000) begin
      c = (which == 0) ? n_bg : (which == 1) ? gold_q.size() : stone_q.size();
      if (c >= target) break;
      @(posedge clk);
      k++;
    end
    chk("wait_req", 32'(c >= target), 32'd1);
  endtask

  initial begin
    int k;
    logic hit;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(draw_sel), 0);
    chk("rst_idx", 32'(obj_index), 0);
    chk("rst_en", 32'({en_bg, en_gold, en_stone, frame_done, frame_overrun}), 0);
    resetn = 1'b1;
    clr();

    // Empty masks: background only, fixed scan latency
    pulse_tick();
    wait_fd("t1");
    #1;
    chk("t1_bg_lat", 32'(bg_en_cyc - tick_cyc), 1);
    chk("t1_n_bg", 32'(n_bg), 1);
    chk("t1_n_obj", 32'(gold_q.size() + stone_q.size()), 0);
    chk("t1_n_fd", 32'(n_fd), 1);
    chk("t1_fd_lat", 32'(fd_cyc - bgd_cyc), 19);
    chk("t1_busy", 32'(busy), 0);

    // Sparse masks
    gold_valid = 8'h05; stone_valid = 8'h80;
    clr();
    pulse_tick();
    wait_fd("t2");
    chk("t2_gold_n", 32'(gold_q.size()), 2);
    chk("t2_gold_idx", pack(gold_q), 32'h02);
    chk("t2_stone_n", 32'(stone_q.size()), 1);
    chk("t2_stone_idx", pack(stone_q), 32'h7);
    chk("t2_sel_seq", pack(sel_q), 32'h1223);
    chk("t2_n_fd", 32'(n_fd), 1);

    // Mask change mid-frame is ignored until the next tick
    stone_valid = 8'h00;
    clr();
    pulse_tick();
    wait_cnt(1, 1);
    #1 gold_valid = 8'hFF;
    wait_fd("t3");
    chk("t3_gold_n", 32'(gold_q.size()), 2);
    chk("t3_gold_idx", pack(gold_q), 32'h02);
    clr();
    pulse_tick();
    wait_fd("t3b");
    chk("t3b_gold_n", 32'(gold_q.size()), 8);
    chk("t3b_gold_idx", pack(gold_q), 32'h01234567);

    // Overrun: tick in GOLD_WAIT and in FRAME_DONE
    gold_valid = 8'h01; gold_dly = 4;
    clr();
    pulse_tick();
    wait_cnt(1, 1);
    #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    hit = 1'b0;
    k = 0;
    while (!hit && k < 200) begin
      @(posedge clk); #1;
      if (frame_done) begin
        hit = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
      end
      k++;
    end
    chk("t4_fd_hit", 32'(hit), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_n_ovr", 32'(n_ovr), 2);
    chk("t4_n_bg", 32'(n_bg), 1);
    chk("t4_n_fd", 32'(n_fd), 1);
    chk("t4_gold_n", 32'(gold_q.size()), 1);
    chk("t4_busy", 32'(busy), 0);

    // Spurious done pulses
    gold_valid = 8'h00; bg_dly = 10; gold_dly = 2;
    clr();
    pulse_tick();
    wait_cnt(0, 1);
    #1 spur_gold = 1'b1;
    @(posedge clk); #1 spur_gold = 1'b0;
    #1;
    chk("t5_bg_hold_sel", 32'(draw_sel), 1);
    chk("t5_bg_hold_busy", 32'(busy), 1);
    wait_fd("t5");
    chk("t5_gold_n", 32'(gold_q.size()), 0);
    @(posedge clk); #1 spur_stone = 1'b1;
    @(posedge clk); #1 spur_stone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_stone", 32'(stone_q.size()), 0);
    chk("t5_idle_fd", 32'(n_fd), 1);

    // Async reset in STONE_WAIT
    bg_dly = 5; stone_valid = 8'h01; stone_dly = 0;
    clr();
    pulse_tick();
    wait_cnt(2, 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_sel", 32'(draw_sel), 0);
    chk("t6_rst_idx", 32'(obj_index), 0);
    chk("t6_rst_en", 32'({en_bg, en_gold, en_stone, frame_done, frame_overrun}), 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (30) @(posedge clk);
    chk("t6_no_fd", 32'(n_fd), 0);
    stone_valid = 8'h00; stone_dly = 2;
    clr();
    pulse_tick();
    wait_fd("t6b");
    chk("t6b_bg_lat", 32'(bg_en_cyc - tick_cyc), 1);
    chk("t6b_n_bg", 32'(n_bg), 1);
    chk("t6b_stone_n", 32'(stone_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/draw_scene_sequencer.md
Name: draw_scene_sequencer

Overview:
Frame-level initiator for the gold, stone and background drawing FSMs. On each frame tick it requests a full background redraw. It then requests one draw per present gold object and one per present stone object. Each request uses the drawers' enable/done handshake. It also owns the select that tells the VGA write mux which drawer currently drives x/y/colour/writeEn.

Parameters:
NUM_GOLD, 8, number of gold object slots (1..15)
NUM_STONE, 8, number of stone object slots (1..15)
IDX_W, 4, object index width; must satisfy 2^IDX_W > max(NUM_GOLD, NUM_STONE)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse requesting a new frame redraw
gold_valid  in  NUM_GOLD  bit i=1: gold slot i is present and must be drawn
stone_valid  in  NUM_STONE  bit i=1: stone slot i is present and must be drawn
draw_background_done  in  1  one-cycle pulse from the background drawer
draw_gold_done  in  1  one-cycle pulse from the gold drawer
draw_stone_done  in  1  one-cycle pulse from the stone drawer
enable_draw_background  out  1  one-cycle request pulse to the background drawer
enable_draw_gold  out  1  one-cycle request pulse to the gold drawer
enable_draw_stone  out  1  one-cycle request pulse to the stone drawer
obj_index  out  IDX_W  slot index of the gold/stone being drawn; valid from REQ through WAIT
draw_sel  out  2  VGA mux owner: 0 none, 1 background, 2 gold, 3 stone
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the frame is complete
frame_overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset (async, resetn=0): state=IDLE. All outputs 0, obj_index=0, latched masks=0. The reset takes effect mid-operation with no completion pulse.
- All outputs are Moore-decoded from state/registers, except frame_overrun, which is a registered pulse.
- States: IDLE, BG_REQ, BG_WAIT, GOLD_SCAN, GOLD_REQ, GOLD_WAIT, STONE_SCAN, STONE_REQ, STONE_WAIT, FRAME_DONE.
- IDLE: when frame_tick=1, latch gold_valid/stone_valid into internal masks and go to BG_REQ. Changes to the mask inputs mid-frame are ignored until the next tick.
- BG_REQ: enable_draw_background=1 and draw_sel=1 for exactly 1 cycle, then go to BG_WAIT.
- BG_WAIT: draw_sel=1. Hold until draw_background_done=1, then go to GOLD_SCAN with obj_index=0.
- GOLD_SCAN (1 cycle per slot):
  - obj_index==NUM_GOLD: go to STONE_SCAN, obj_index=0.
  - latched gold bit set: go to GOLD_REQ.
  - otherwise: obj_index+1, stay in GOLD_SCAN.
- GOLD_REQ: enable_draw_gold=1 and draw_sel=2 for 1 cycle, then go to GOLD_WAIT.
- GOLD_WAIT: draw_sel=2. On draw_gold_done, obj_index+1 and go to GOLD_SCAN.
- STONE_SCAN/REQ/WAIT: identical to the gold states, using stone signals and draw_sel=3. Exhaustion (obj_index==NUM_STONE) goes to FRAME_DONE.
- FRAME_DONE: frame_done=1 for 1 cycle, draw_sel=0, then go to IDLE.
- draw_sel=0 in IDLE, FRAME_DONE and the SCAN states.
- Done pulses are honoured only in their matching WAIT state. Pulses arriving in any other state are ignored. There is no timeout; a missing done stalls the sequencer.
- Each enable pulse is exactly 1 cycle long; a request is never re-issued while its WAIT state is pending.
- frame_tick in any state other than IDLE (including FRAME_DONE) is dropped, not queued. frame_overrun pulses in the following cycle.
- obj_index increments saturate by construction: the index never exceeds NUM_*, and no wrap-around occurs.
- Latency:
  - frame_tick at edge k gives enable_draw_background high in cycle k+1.
  - With all masks 0 and draw_background_done in cycle t, frame_done is high in cycle t+(NUM_GOLD+1)+(NUM_STONE+1)+1.

Test Plan:
- Reset, then masks gold=0x00, stone=0x00. Pulse frame_tick; return bg done 5 cycles after its enable -> exactly one enable_draw_background; no gold/stone enables; frame_done 19 cycles after the bg done cycle; busy then drops.
- gold=0x05, stone=0x80 -> enable_draw_gold at obj_index 0 then 2; enable_draw_stone at obj_index 7; draw_sel sequence 1,2,2,3; exactly one frame_done.
- Change gold_valid from 0x05 to 0xFF during GOLD_WAIT -> still only indexes 0 and 2 are drawn this frame; the next frame draws all 8.
- frame_tick during GOLD_WAIT and during FRAME_DONE -> frame_overrun pulses once each; no restart; the current frame completes normally.
- Spurious draw_gold_done during BG_WAIT -> ignored, state holds; spurious draw_stone_done in IDLE -> no effect.
- Assert resetn=0 for 1 cycle during STONE_WAIT -> all outputs 0 immediately; no frame_done; the next frame_tick starts cleanly with BG_REQ.
